// File: rtl/gate_truth_table_walker.sv
// Walks every input pattern of an N_IN-input gate, holds each for HOLD
// settle cycles and captures the registered gate output into a truth table.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin a sweep (sampled only while idle)
//   op           gate select latched on accepted start:
//                0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 illegal
//   busy         high whenever a sweep is in progress (any non-idle state)
//   done         one-cycle completion pulse
//   err          latched op was illegal; held until the next accepted start
//   vec_a        pattern currently applied to the gate
//   gate_out     registered gate function of vec_a under the latched op
//   table_q      truth table, bit i = gate result for pattern i
//   table_valid  table_q complete; held until the next accepted start
module gate_truth_table_walker #(
    parameter int N_IN = 2,
    parameter int HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [N_IN-1:0]       vec_a,
    output logic                  gate_out,
    output logic [(1<<N_IN)-1:0]  table_q,
    output logic                  table_valid
);

    localparam int TW = 1 << N_IN;
    localparam int CW = $clog2(HOLD) + 1;
    localparam logic [N_IN-1:0] LAST = N_IN'(TW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            gate_q, gate_d;
    logic [TW-1:0]   tab_q, tab_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            op_legal;

    assign op_legal = (op <= 3'd5);

    // Gate model: reduction of the applied pattern; illegal selects read 0.
    always_comb begin
        gate_d = 1'b0;
        case (op_q)
            3'd0:    gate_d = ~&vec_q;
            3'd1:    gate_d = ~|vec_q;
            3'd2:    gate_d = &vec_q;
            3'd3:    gate_d = |vec_q;
            3'd4:    gate_d = ^vec_q;
            3'd5:    gate_d = ~^vec_q;
            default: gate_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        vec_d   = vec_q;
        tab_d   = tab_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tab_d   = '0;
                    valid_d = 1'b0;
                    err_d   = ~op_legal;
                    state_d = op_legal ? S_APPLY : S_DONE;
                end
            end
            S_APPLY: begin
                vec_d   = idx_q;
                cnt_d   = CW'(HOLD - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CAPTURE: begin
                // gate_q already reflects vec_q: at least one settle cycle
                // separates the pattern update from this capture.
                tab_d[idx_q] = gate_q;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                valid_d = ~err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            vec_q   <= '0;
            gate_q  <= 1'b0;
            tab_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            gate_q  <= gate_d;
            tab_q   <= tab_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign vec_a       = vec_q;
    assign gate_out    = gate_q;
    assign table_q     = tab_q;
    assign table_valid = valid_q;

endmodule

// File: tb/tb_gate_truth_table_walker.sv
// Bench for gate_truth_table_walker: two instances (N_IN=2/HOLD=8 and
// N_IN=3/HOLD=1) share stimulus and are compared to a timing model.
module tb_gate_truth_table_walker;

    localparam int N0 = 2;
    localparam int H0 = 8;
    localparam int N1 = 3;
    localparam int H1 = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op    = 3'd0;

    logic       busy0, done0, err0, gate0, valid0;
    logic [1:0] vec0;
    logic [3:0] table0;
    logic       busy1, done1, err1, gate1, valid1;
    logic [2:0] vec1;
    logic [7:0] table1;

    int checks = 0;
    int errors = 0;
    int vrec [128];

    logic [2:0] dops [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
    logic [3:0] dt0  [4] = '{4'b0111, 4'b0001, 4'b0110, 4'b1001};
    logic [7:0] dt1  [4] = '{8'h7F, 8'h01, 8'h96, 8'h69};

    always #5 clk = ~clk;

    gate_truth_table_walker #(.N_IN(N0), .HOLD(H0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .busy(busy0), .done(done0), .err(err0), .vec_a(vec0),
        .gate_out(gate0), .table_q(table0), .table_valid(valid0)
    );

    gate_truth_table_walker #(.N_IN(N1), .HOLD(H1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .busy(busy1), .done(done1), .err(err1), .vec_a(vec1),
        .gate_out(gate1), .table_q(table1), .table_valid(valid1)
    );

    // Reference model state, one slot per instance.
    // mn counts clock edges since the accepting edge (1 = accept edge).
    int        mn    [2];
    bit        mact  [2];
    bit [2:0]  mop   [2];
    bit [3:0]  mvec  [2];
    bit [15:0] mtab  [2];
    bit        mval  [2];
    bit        merr  [2];
    bit        mgate [2];

    function automatic bit gfun(input bit [2:0] o, input int v, input int n);
        bit all1, any1, par;
        all1 = (v == (1 << n) - 1);
        any1 = (v != 0);
        par  = ($countones(v) % 2) == 1;
        case (o)
            3'd0:    return !all1;
            3'd1:    return !any1;
            3'd2:    return all1;
            3'd3:    return any1;
            3'd4:    return par;
            3'd5:    return !par;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int finish_at(input int k);
        int n, h;
        n = k ? N1 : N0;
        h = k ? H1 : H0;
        return merr[k] ? 1 : (1 << n) * (h + 2) + 1;
    endfunction

    task automatic mreset(input int k);
        mn[k] = 0; mact[k] = 0; mop[k] = 0; mvec[k] = 0;
        mtab[k] = 0; mval[k] = 0; merr[k] = 0; mgate[k] = 0;
    endtask

    task automatic step(input int k);
        int n, h, pi;
        bit g;
        n = k ? N1 : N0;
        h = k ? H1 : H0;
        g = gfun(mop[k], int'(mvec[k]), n);
        if (!mact[k]) begin
            if (start) begin
                mact[k] = 1; mn[k] = 1; mop[k] = op;
                mtab[k] = 0; mval[k] = 0; merr[k] = (op > 3'd5);
            end
        end else begin
            mn[k]++;
            if (mn[k] > finish_at(k)) begin
                mact[k] = 0;
                if (!merr[k]) mval[k] = 1;
            end else if (!merr[k]) begin
                if ((mn[k] - 2) % (h + 2) == 0)
                    mvec[k] = 4'((mn[k] - 2) / (h + 2));
                if (mn[k] >= h + 3 && (mn[k] - 1) % (h + 2) == 0) begin
                    pi = (mn[k] - 1) / (h + 2) - 1;
                    mtab[k][pi] = gfun(mop[k], pi, n);
                end
            end
        end
        mgate[k] = g;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end else begin
            step(0);
            step(1);
        end
    end

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    task automatic cmp(input int k, input logic b, input logic d, input logic e,
                       input logic [3:0] v, input logic g, input logic [7:0] t,
                       input logic tv);
        chk($sformatf("i%0d_busy", k), 16'(b), 16'(mact[k]));
        chk($sformatf("i%0d_done", k), 16'(d), 16'(mact[k] && mn[k] == finish_at(k)));
        chk($sformatf("i%0d_err", k), 16'(e), 16'(merr[k]));
        chk($sformatf("i%0d_vec_a", k), 16'(v), 16'(mvec[k]));
        chk($sformatf("i%0d_gate_out", k), 16'(g), 16'(mgate[k]));
        chk($sformatf("i%0d_table", k), 16'(t), 16'(mtab[k][7:0]));
        chk($sformatf("i%0d_table_valid", k), 16'(tv), 16'(mval[k]));
    endtask

    always @(negedge clk) begin
        cmp(0, busy0, done0, err0, {2'b00, vec0}, gate0, {4'b0000, table0}, valid0);
        cmp(1, busy1, done1, err1, {1'b0, vec1}, gate1, table1, valid1);
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy0 || busy1); i++) tick();
        chk("idle_timeout", 16'(busy0 | busy1), 16'd0);
    endtask

    task automatic sweep(input logic [2:0] o, input int inj,
                         output int l0, output int l1,
                         output logic [3:0] t0, output logic [7:0] t1,
                         output logic e0);
        int n;
        wait_idle();
        op = o;
        start = 1'b1;
        tick();
        start = 1'b0;
        l0 = 0; l1 = 0; n = 0; t0 = '0; t1 = '0; e0 = 1'b0;
        while ((l0 == 0 || l1 == 0) && n < 120) begin
            @(negedge clk);
            n++;
            vrec[n] = int'(vec1);
            if (done0 && l0 == 0) begin
                l0 = n; t0 = table0; e0 = err0;
            end
            if (done1 && l1 == 0) begin
                l1 = n; t1 = table1;
            end
            if (inj != 0 && n == inj) begin
                #1; op = 3'd3; start = 1'b1;
            end else if (inj != 0 && n == inj + 1) begin
                #1; start = 1'b0;
            end
        end
        chk("sweep_done_seen", 16'(l0 != 0 && l1 != 0), 16'd1);
    endtask

    initial begin
        int l0, l1;
        logic [3:0] t0;
        logic [7:0] t1;
        logic e0;

        repeat (3) tick();
        chk("rst_busy", 16'(busy0), 16'd0);
        chk("rst_table", 16'(table0), 16'd0);
        chk("rst_gate", 16'(gate0), 16'd0);
        chk("rst_vec1", 16'(vec1), 16'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            sweep(dops[i], 0, l0, l1, t0, t1, e0);
            chk($sformatf("op%0d_lat0", dops[i]), 16'(l0), 16'd41);
            chk($sformatf("op%0d_lat1", dops[i]), 16'(l1), 16'd25);
            chk($sformatf("op%0d_table0", dops[i]), 16'(t0), 16'(dt0[i]));
            chk($sformatf("op%0d_table1", dops[i]), 16'(t1), 16'(dt1[i]));
            chk($sformatf("op%0d_err0", dops[i]), 16'(e0), 16'd0);
            @(negedge clk);
            chk($sformatf("op%0d_valid0", dops[i]), 16'(valid0), 16'd1);
            chk($sformatf("op%0d_idle0", dops[i]), 16'(busy0), 16'd0);
        end

        sweep(3'd6, 0, l0, l1, t0, t1, e0);
        chk("ill_lat0", 16'(l0), 16'd1);
        chk("ill_lat1", 16'(l1), 16'd1);
        chk("ill_err0", 16'(e0), 16'd1);
        chk("ill_table0", 16'(t0), 16'd0);
        @(negedge clk);
        chk("ill_busy0", 16'(busy0), 16'd0);
        chk("ill_valid0", 16'(valid0), 16'd0);
        chk("ill_err_held", 16'(err0), 16'd1);

        sweep(3'd0, 10, l0, l1, t0, t1, e0);
        chk("inj_lat0", 16'(l0), 16'd41);
        chk("inj_table0", 16'(t0), 16'b0111);

        wait_idle();
        op = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy0", 16'(busy0), 16'd0);
        chk("arst_done0", 16'(done0), 16'd0);
        chk("arst_vec0", 16'(vec0), 16'd0);
        chk("arst_table0", 16'(table0), 16'd0);
        chk("arst_valid0", 16'(valid0), 16'd0);
        chk("arst_busy1", 16'(busy1), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sweep(3'd3, 0, l0, l1, t0, t1, e0);
        chk("or_lat0", 16'(l0), 16'd41);
        chk("or_table0", 16'(t0), 16'b1110);
        chk("or_table1", 16'(t1), 16'hFE);

        sweep(3'd2, 0, l0, l1, t0, t1, e0);
        chk("and_lat1", 16'(l1), 16'd25);
        chk("and_table1", 16'(t1), 16'h80);
        chk("and_table0", 16'(t0), 16'b1000);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("and_vec1_step%0d_a", k), 16'(vrec[2 + 3 * k]), 16'(k));
            chk($sformatf("and_vec1_step%0d_b", k), 16'(vrec[4 + 3 * k]), 16'(k));
        end

        wait_idle();
        op = 3'd6;
        start = 1'b1;
        tick();
        @(negedge clk);
        chk("b2b_first_busy", 16'(busy0), 16'd1);
        chk("b2b_first_done", 16'(done0), 16'd1);
        tick();
        @(negedge clk);
        chk("b2b_idle_gap", 16'(busy0), 16'd0);
        tick();
        @(negedge clk);
        chk("b2b_second_done", 16'(done0), 16'd1);
        #1;
        start = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            tick();
            start = ($urandom_range(0, 5) == 0);
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (60) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
